modulo_controle_engarrafamento_param: RTL and testbench
=======================================================

MODULO_CONTROLE_ENGARRAFAMENTO_PARAM -- requirements
Module: modulo_controle_engarrafamento_param

Interface
REQ-001 SHALL have parameter LOTE, default 12, bottles per batch (>=2).
REQ-002 SHALL have parameter LOTES_MAX, default 10, batch-counter modulus (>=2).
REQ-003 SHALL have parameter CAP_ROLHAS, default 99, cork reservoir capacity (1..127).
REQ-004 SHALL have parameter LIMIAR_ROLHAS, default 5, low-cork alarm threshold (<CAP_ROLHAS).
REQ-005 SHALL have parameter RECARGA, default 20, corks added per refill request.
REQ-006 SHALL have derived localparams WR=clog2(CAP_ROLHAS+1), WG=clog2(LOTE), WL=clog2(LOTES_MAX).
REQ-007 SHALL have port clk input 1: single clock; all state updates on rising edge.
REQ-008 SHALL have port clr input 1: reset, synchronous, active-low.
REQ-009 SHALL have port enable input 1: line run (1) / stop (0).
REQ-010 SHALL have port pg input 1: bottle in position.
REQ-011 SHALL have port ch input 1: bottle full.
REQ-012 SHALL have port cq input 1: cork seated.
REQ-013 SHALL have port op_add input 1: manual single-cork insert, debounced level.
REQ-014 SHALL have port op_recarga input 1: refill request, debounced level.
REQ-015 SHALL have port m output 1: conveyor motor.
REQ-016 SHALL have port ev output 1: fill valve.
REQ-017 SHALL have port ve output 1: sealer.
REQ-018 SHALL have port al output 1: low-cork alarm.
REQ-019 SHALL have port estado output 2: FSM state code.
REQ-020 SHALL have port rolhas output WR: corks in reservoir.
REQ-021 SHALL have port cnt_garrafas output WG: bottles in current batch.
REQ-022 SHALL have port cnt_lotes output WL: completed batches, modulo LOTES_MAX.
REQ-023 SHALL have port lote_ok output 1: one-cycle pulse on batch completion.

Function
REQ-024 SHALL implement Moore FSM: PARADO=00, TRANSPORTE=01, ENCHENDO=10, VEDANDO=11; estado = state code.
REQ-025 SHALL drive m=1 only in TRANSPORTE, ev=1 only in ENCHENDO, ve=1 only in VEDANDO.
REQ-026 SHALL go to PARADO on next edge from any state when enable=0 (highest FSM priority).
REQ-027 SHALL go PARADO->TRANSPORTE when enable=1 and rolhas>0; else hold PARADO.
REQ-028 SHALL go TRANSPORTE->ENCHENDO when pg=1.
REQ-029 SHALL go ENCHENDO->VEDANDO when ch=1 and rolhas>0; ch=1 with rolhas=0 holds ENCHENDO.
REQ-030 SHALL, in VEDANDO with cq=1, generate one consume event and go to TRANSPORTE the same edge.
REQ-031 SHALL detect rising edges of op_add and op_recarga internally (one registered sample each); held levels count once.
REQ-032 SHALL update rolhas each edge as clamp(rolhas - consume + add_edge + RECARGA*recarga_edge, 0, CAP_ROLHAS), net computed in WR+2-bit signed arithmetic, all simultaneous events applied together.
REQ-033 SHALL drive al = (rolhas < LIMIAR_ROLHAS), combinational from the register.
REQ-034 SHALL, on consume, increment cnt_garrafas; at LOTE-1 wrap to 0, increment cnt_lotes and assert lote_ok for that cycle.
REQ-035 SHALL wrap cnt_lotes from LOTES_MAX-1 to 0 with no other effect.
REQ-036 SHALL keep counters and rolhas unchanged by enable; only clr clears them.
REQ-037 SHALL assert lote_ok at most once per consume event; never while in reset.

Reset
REQ-038 SHALL, when clr=0 at an edge: state PARADO, rolhas=0, cnt_garrafas=0, cnt_lotes=0, lote_ok=0, edge-detect registers=0.
REQ-039 SHALL therefore present after reset m=ev=ve=0, estado=00, al=1 (LIMIAR_ROLHAS>0).
REQ-040 SHALL abort any cycle in progress on mid-operation reset, no consume event generated.

Verification
REQ-041 SHALL cover reset then op_recarga pulse -> rolhas=20, al=0; enable=1 -> estado 01 next edge.
REQ-042 SHALL cover full cycle pg, ch, cq -> states 01->10->11->01, rolhas 20->19, cnt_garrafas 0->1.
REQ-043 SHALL cover 12 cycles -> cnt_garrafas wraps to 0, cnt_lotes=1, lote_ok high exactly one cycle; 120 cycles -> cnt_lotes wraps to 0.
REQ-044 SHALL cover rolhas=0 in ENCHENDO with ch=1 -> holds 10, ev=1, al=1; op_add edge -> rolhas=1, VEDANDO next edge.
REQ-045 SHALL cover saturation: rolhas=90 + op_recarga -> 99; cq consume same edge as op_add -> rolhas unchanged.
REQ-046 SHALL cover enable=0 in VEDANDO -> PARADO next edge, rolhas/counters unchanged; clr=0 mid-cycle -> all REQ-038 values.

Source files
------------

// File: rtl/modulo_controle_engarrafamento_param.sv
// modulo_controle_engarrafamento_param: bottling line controller with cork reservoir and batch counters
module modulo_controle_engarrafamento_param #(
  parameter int LOTE = 12,
  parameter int LOTES_MAX = 10,
  parameter int CAP_ROLHAS = 99,
  parameter int LIMIAR_ROLHAS = 5,
  parameter int RECARGA = 20,
  localparam int WR = $clog2(CAP_ROLHAS + 1),
  localparam int WG = $clog2(LOTE),
  localparam int WL = $clog2(LOTES_MAX)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          enable,
  input  logic          pg,
  input  logic          ch,
  input  logic          cq,
  input  logic          op_add,
  input  logic          op_recarga,
  output logic          m,
  output logic          ev,
  output logic          ve,
  output logic          al,
  output logic [1:0]    estado,
  output logic [WR-1:0] rolhas,
  output logic [WG-1:0] cnt_garrafas,
  output logic [WL-1:0] cnt_lotes,
  output logic          lote_ok
);
  localparam int WN = WR + 2;
  typedef enum logic [1:0] {PARADO = 2'b00, TRANSPORTE = 2'b01, ENCHENDO = 2'b10, VEDANDO = 2'b11} state_t;
  state_t state, state_d;
  logic add_q, rec_q, add_e, rec_e, cons, wrap_g;
  logic signed [WN-1:0] net;
  logic [WR-1:0] rolhas_d;
  assign add_e = op_add & ~add_q;
  assign rec_e = op_recarga & ~rec_q;
  // a stop request wins over sealing, so no cork is consumed when enable drops in VEDANDO
  assign cons = enable && state == VEDANDO && cq;
  assign wrap_g = cnt_garrafas == WG'(LOTE - 1);
  assign net = $signed({2'b00, rolhas}) - $signed(WN'(cons)) + $signed(WN'(add_e))
             + (rec_e ? $signed(WN'(RECARGA)) : $signed(WN'(0)));
  assign rolhas_d = net[WN-1] ? '0 : net > $signed(WN'(CAP_ROLHAS)) ? WR'(CAP_ROLHAS) : net[WR-1:0];
  assign m = state == TRANSPORTE;
  assign ev = state == ENCHENDO;
  assign ve = state == VEDANDO;
  assign al = rolhas < WR'(LIMIAR_ROLHAS);
  assign estado = state;
  always_comb begin
    state_d = state;
    if (!enable) state_d = PARADO;
    else
      case (state)
        PARADO:     state_d = |rolhas ? TRANSPORTE : PARADO;
        TRANSPORTE: state_d = pg ? ENCHENDO : TRANSPORTE;
        ENCHENDO:   state_d = ch && |rolhas ? VEDANDO : ENCHENDO;
        VEDANDO:    state_d = cq ? TRANSPORTE : VEDANDO;
      endcase
  end
  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= PARADO;
      rolhas <= '0;
      cnt_garrafas <= '0;
      cnt_lotes <= '0;
      lote_ok <= 1'b0;
      add_q <= 1'b0;
      rec_q <= 1'b0;
    end else begin
      state <= state_d;
      rolhas <= rolhas_d;
      add_q <= op_add;
      rec_q <= op_recarga;
      lote_ok <= cons && wrap_g;
      if (cons) begin
        cnt_garrafas <= wrap_g ? '0 : cnt_garrafas + WG'(1);
        if (wrap_g) cnt_lotes <= cnt_lotes == WL'(LOTES_MAX - 1) ? '0 : cnt_lotes + WL'(1);
      end
    end
  end
endmodule

// File: tb/tb_modulo_controle_engarrafamento_param.sv
// tb_modulo_controle_engarrafamento_param: directed stimulus with queued expectations checked by a monitor
module tb_modulo_controle_engarrafamento_param;
  logic clk = 0, clr = 0, enable = 0, pg = 0, ch = 0, cq = 0, op_add = 0, op_recarga = 0;
  logic m, ev, ve, al, lote_ok;
  logic [1:0] estado;
  logic [6:0] rolhas;
  logic [3:0] cnt_garrafas, cnt_lotes;
  typedef struct {string nm; int est; int rol; int cg; int cl; int lok;} exp_t;
  exp_t q[$];
  exp_t e;
  int compared = 0, mismatched = 0;
  int rol_m = 0, cg_m = 0, cl_m = 0;
  modulo_controle_engarrafamento_param dut (
    .clk(clk), .clr(clr), .enable(enable), .pg(pg), .ch(ch), .cq(cq),
    .op_add(op_add), .op_recarga(op_recarga), .m(m), .ev(ev), .ve(ve), .al(al),
    .estado(estado), .rolhas(rolhas), .cnt_garrafas(cnt_garrafas),
    .cnt_lotes(cnt_lotes), .lote_ok(lote_ok)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, int act, int exp);
    if (exp < 0) return;
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.nm, ".estado"}, int'(estado), e.est);
      chk({e.nm, ".m_ev_ve"}, int'({m, ev, ve}),
          e.est < 0 ? -1 : e.est == 1 ? 4 : e.est == 2 ? 2 : e.est == 3 ? 1 : 0);
      chk({e.nm, ".rolhas"}, int'(rolhas), e.rol);
      chk({e.nm, ".al"}, int'(al), e.rol < 0 ? -1 : int'(e.rol < 5));
      chk({e.nm, ".cnt_garrafas"}, int'(cnt_garrafas), e.cg);
      chk({e.nm, ".cnt_lotes"}, int'(cnt_lotes), e.cl);
      chk({e.nm, ".lote_ok"}, int'(lote_ok), e.lok);
    end
  end
  task automatic step(string nm, logic c, logic en, logic p, logic h, logic k, logic a, logic r,
                      int est, int rol, int cg, int cl, int lok);
    @(negedge clk);
    clr = c; enable = en; pg = p; ch = h; cq = k; op_add = a; op_recarga = r;
    @(posedge clk);
    q.push_back('{nm, est, rol, cg, cl, lok});
  endtask
  // expected bookkeeping for one sealed bottle; returns 1 when the batch completes
  function automatic int consume();
    int wrap = int'(cg_m == 11);
    rol_m--;
    cg_m = wrap != 0 ? 0 : cg_m + 1;
    if (wrap != 0) cl_m = (cl_m + 1) % 10;
    return wrap;
  endfunction
  task automatic bottle(bit refill);
    int w;
    if (refill && rol_m < 3) begin
      rol_m += 20;
      step("refill", 1, 1, 0, 0, 0, 0, 1, 1, rol_m, cg_m, cl_m, 0);
    end
    step("pg", 1, 1, 1, 0, 0, 0, 0, 2, rol_m, cg_m, cl_m, 0);
    step("ch", 1, 1, 0, 1, 0, 0, 0, 3, rol_m, cg_m, cl_m, 0);
    w = consume();
    step("cq", 1, 1, 0, 0, 1, 0, 0, 1, rol_m, cg_m, cl_m, w);
  endtask
  initial begin
    int w;
    step("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset2", 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    rol_m = 20;
    step("recarga", 1, 0, 0, 0, 0, 0, 1, 0, 20, 0, 0, 0);
    step("enable", 1, 1, 0, 0, 0, 0, 0, 1, 20, 0, 0, 0);
    bottle(1);
    repeat (11) bottle(1);
    repeat (108) bottle(1);
    while (rol_m > 0) bottle(0);
    step("pg_empty", 1, 1, 1, 0, 0, 0, 0, 2, 0, cg_m, cl_m, 0);
    step("ch_hold", 1, 1, 0, 1, 0, 0, 0, 2, 0, cg_m, cl_m, 0);
    step("ch_hold2", 1, 1, 0, 1, 0, 0, 0, 2, 0, cg_m, cl_m, 0);
    rol_m = 1;
    step("add_empty", 1, 1, 0, 1, 0, 1, 0, 2, 1, cg_m, cl_m, 0);
    step("seal_after_add", 1, 1, 0, 1, 0, 1, 0, 3, 1, cg_m, cl_m, 0);
    w = consume();
    step("cq_last", 1, 1, 0, 0, 1, 0, 0, 1, 0, cg_m, cl_m, w);
    step("stop", 1, 0, 0, 0, 0, 0, 0, 0, 0, cg_m, cl_m, 0);
    for (int i = 0; i < 4; i++) begin
      rol_m += 20;
      step("rec_rise", 1, 0, 0, 0, 0, 0, 1, 0, rol_m, cg_m, cl_m, 0);
      step("rec_held", 1, 0, 0, 0, 0, 0, 1, 0, rol_m, cg_m, cl_m, 0);
      step("rec_low", 1, 0, 0, 0, 0, 0, 0, 0, rol_m, cg_m, cl_m, 0);
    end
    for (int i = 0; i < 10; i++) begin
      rol_m++;
      step("add_rise", 1, 0, 0, 0, 0, 1, 0, 0, rol_m, cg_m, cl_m, 0);
      step("add_low", 1, 0, 0, 0, 0, 0, 0, 0, rol_m, cg_m, cl_m, 0);
    end
    step("rec_sat", 1, 0, 0, 0, 0, 0, 1, 0, 99, cg_m, cl_m, 0);
    step("rec_sat_low", 1, 0, 0, 0, 0, 0, 0, 0, 99, cg_m, cl_m, 0);
    step("add_sat", 1, 0, 0, 0, 0, 1, 0, 0, 99, cg_m, cl_m, 0);
    step("add_sat_low", 1, 0, 0, 0, 0, 0, 0, 0, 99, cg_m, cl_m, 0);
    rol_m = 99;
    step("run", 1, 1, 0, 0, 0, 0, 0, 1, 99, cg_m, cl_m, 0);
    step("pg_full", 1, 1, 1, 0, 0, 0, 0, 2, 99, cg_m, cl_m, 0);
    step("ch_full", 1, 1, 0, 1, 0, 0, 0, 3, 99, cg_m, cl_m, 0);
    w = consume();
    rol_m = 99;
    step("cq_and_add", 1, 1, 0, 0, 1, 1, 0, 1, 99, cg_m, cl_m, w);
    step("pg_b", 1, 1, 1, 0, 0, 0, 0, 2, 99, cg_m, cl_m, 0);
    step("ch_b", 1, 1, 0, 1, 0, 0, 0, 3, 99, cg_m, cl_m, 0);
    step("stop_sealing", 1, 0, 0, 0, 1, 0, 0, 0, 99, cg_m, cl_m, 0);
    step("restart", 1, 1, 0, 0, 0, 0, 0, 1, 99, cg_m, cl_m, 0);
    step("pg_c", 1, 1, 1, 0, 0, 0, 0, 2, 99, cg_m, cl_m, 0);
    step("ch_c", 1, 1, 0, 1, 0, 0, 0, 3, 99, cg_m, cl_m, 0);
    step("reset_mid", 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("empty_hold", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
